// File: rtl/nd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nd_pkg
// Description : Shared types and constants for the two-approach track
//               interlock (nd). Holds the FSM state encoding, the grant
//               flag encoding, counter width and default timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package nd_pkg;

  // Width of the shared hold/gap down-counter.
  localparam int CNT_W = 8;

  // Default timing, in clock cycles.
  localparam int HOLD_DEFAULT = 2;
  localparam int GAP_DEFAULT  = 1;

  // Interlock FSM states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROUTE1 = 3'd1,
    ST_ROUTE2 = 3'd2,
    ST_HOLD1  = 3'd3,
    ST_HOLD2  = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  // Which route was granted most recently (round-robin arbitration).
  typedef enum logic {
    GRANT1 = 1'b0,
    GRANT2 = 1'b1
  } grant_t;

  // Counter reload value for a phase lasting 'cycles' clock cycles: the
  // counter is checked for zero before decrementing, so it starts at N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    int tmp;
    tmp = cycles - 1;
    return tmp[CNT_W-1:0];
  endfunction

endpackage : nd_pkg
`default_nettype wire

// File: rtl/nd_sync.sv
`default_nettype none
// ============================================================================
// Module      : nd_sync
// Description : Two-flop level synchronizer for one asynchronous sensor.
//               Both flops clear on synchronous active-low reset.
// Ports       : clk  - system clock (rising edge)
//               rest - synchronous reset, active-low
//               din  - asynchronous level input
//               dout - synchronized level (two clocks of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module nd_sync (
  input  logic clk,
  input  logic rest,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rest) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule : nd_sync
`default_nettype wire

// File: rtl/nd.sv
`default_nettype none
// ============================================================================
// Module      : nd
// Description : Two-approach track switch interlock. Each approach sensor is
//               synchronized, then a single FSM grants at most one route at
//               a time, holds it for HOLD_CYCLES after the sensor drops, and
//               forces a GAP_CYCLES dead band before any new route is set.
//               Simultaneous requests from IDLE are arbitrated round-robin.
// Ports       : clk     - system clock (rising edge)
//               rest    - synchronous reset, active-low
//               sensor1 - approach 1 train detector (async level, high)
//               sensor2 - approach 2 train detector (async level, high)
//               switch1 - registered, 1 = track set for route 1
//               switch2 - registered, 1 = track set for route 2
// Parameters  : HOLD_CYCLES - hold time after sensor release (1..255)
//               GAP_CYCLES  - dead band between routes (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module nd
  import nd_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int GAP_CYCLES  = GAP_DEFAULT
) (
  input  logic clk,
  input  logic rest,
  input  logic sensor1,
  input  logic sensor2,
  output logic switch1,
  output logic switch2
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = cnt_load(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD  = cnt_load(GAP_CYCLES);

  logic s1;
  logic s2;

  nd_sync u_sync1 (
    .clk  (clk),
    .rest (rest),
    .din  (sensor1),
    .dout (s1)
  );

  nd_sync u_sync2 (
    .clk  (clk),
    .rest (rest),
    .din  (sensor2),
    .dout (s2)
  );

  state_t           state;
  grant_t           last_grant;
  logic [CNT_W-1:0] cnt;

  // Single registered FSM. The switch outputs are decoded from the state
  // held before this edge, so they follow the state by one register stage;
  // because they come from one state value they can never both be 1.
  always_ff @(posedge clk) begin
    if (!rest) begin
      state      <= ST_IDLE;
      last_grant <= GRANT2;   // route 1 wins the first tie after reset
      cnt        <= '0;
      switch1    <= 1'b0;
      switch2    <= 1'b0;
    end else begin
      switch1 <= (state == ST_ROUTE1) || (state == ST_HOLD1);
      switch2 <= (state == ST_ROUTE2) || (state == ST_HOLD2);

      case (state)
        ST_IDLE: begin
          if (s1 && s2) begin
            // Tie: serve whichever route was not granted last.
            if (last_grant == GRANT2) begin
              state      <= ST_ROUTE1;
              last_grant <= GRANT1;
            end else begin
              state      <= ST_ROUTE2;
              last_grant <= GRANT2;
            end
          end else if (s1) begin
            state      <= ST_ROUTE1;
            last_grant <= GRANT1;
          end else if (s2) begin
            state      <= ST_ROUTE2;
            last_grant <= GRANT2;
          end
        end

        ST_ROUTE1: begin
          if (!s1) begin
            state <= ST_HOLD1;
            cnt   <= HOLD_LOAD;
          end
        end

        ST_ROUTE2: begin
          if (!s2) begin
            state <= ST_HOLD2;
            cnt   <= HOLD_LOAD;
          end
        end

        ST_HOLD1: begin
          if (s1) begin
            state <= ST_ROUTE1;
          end else if (cnt == '0) begin
            state <= ST_GAP;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_HOLD2: begin
          if (s2) begin
            state <= ST_ROUTE2;
          end else if (cnt == '0) begin
            state <= ST_GAP;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_GAP: begin
          // Sensors are ignored here; pending requests are levels and are
          // picked up again from IDLE.
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : nd
`default_nettype wire

// File: tb/tb_nd.sv
`default_nettype none
// ============================================================================
// Module      : tb_nd
// Description : Self-checking bench for nd. A behavioural model (route owner,
//               quiet-cycle count, gap count, two-deep sensor delay line and
//               one-cycle output lag) predicts both switches every cycle;
//               directed steps cover reset, latency, sequential and
//               simultaneous requests, round-robin, random traffic with
//               random resets, and mid-route reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nd;

  localparam int HOLD = 2;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic rest = 1'b0;
  logic sensor1 = 1'b0;
  logic sensor2 = 1'b0;
  logic switch1;
  logic switch2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nd #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk     (clk),
    .rest    (rest),
    .sensor1 (sensor1),
    .sensor2 (sensor2),
    .switch1 (switch1),
    .switch2 (switch2)
  );

  // Reference model state.
  bit m_d1a, m_d2a, m_d1b, m_d2b;  // sensor delay line (two edges)
  int owner = 0;                   // 0 = no route, 1/2 = route owner
  int quiet = 0;                   // cycles owner's sensor has been low
  int gap   = 0;                   // remaining dead-band cycles
  int last  = 2;                   // last granted route
  bit e_sw1 = 1'b0;
  bit e_sw2 = 1'b0;

  task automatic model_edge();
    bit s1, s2, sown;
    if (!rest) begin
      m_d1a = 0; m_d2a = 0; m_d1b = 0; m_d2b = 0;
      owner = 0; quiet = 0; gap = 0; last = 2;
      e_sw1 = 0; e_sw2 = 0;
    end else begin
      s1 = m_d2a;
      s2 = m_d2b;
      // Outputs show who owned the track before this edge.
      e_sw1 = (owner == 1);
      e_sw2 = (owner == 2);
      if (owner != 0) begin
        sown = (owner == 1) ? s1 : s2;
        if (sown) quiet = 0;
        else if (quiet == HOLD) begin
          owner = 0;
          gap   = GAP;
        end else quiet++;
      end else if (gap > 0) begin
        gap--;
      end else if (s1 || s2) begin
        if (s1 && s2) owner = (last == 1) ? 2 : 1;
        else          owner = s1 ? 1 : 2;
        last  = owner;
        quiet = 0;
      end
      m_d2a = m_d1a; m_d1a = sensor1;
      m_d2b = m_d1b; m_d1b = sensor2;
    end
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: update model at the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("sw1", switch1, e_sw1);
    check("sw2", switch2, e_sw2);
    check("mutex", switch1 & switch2, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic hist [0:7];
  bit   saw1, saw2;

  initial begin
    // Reset held two cycles while sensors toggle: outputs stay low.
    rest = 0; sensor1 = 1; sensor2 = 0;
    tick();
    sensor1 = 0; sensor2 = 1;
    tick();
    check("rst_sw1", switch1, 1'b0);
    check("rst_sw2", switch2, 1'b0);
    rest = 1; sensor2 = 0;
    ticks(4);

    // Single one-cycle request: switch1 high after edges k+3..k+5.
    sensor1 = 1;
    tick();
    hist[0] = switch1;
    sensor1 = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      hist[i] = switch1;
    end
    check("lat_k2", hist[2], 1'b0);
    check("lat_k3", hist[3], 1'b1);
    check("lat_k5", hist[5], 1'b1);
    check("lat_k6", hist[6], 1'b0);
    ticks(4);

    // Sequential pulses: short sensor2 pulse is lost during route 1.
    sensor1 = 1;
    tick();
    sensor1 = 0; sensor2 = 1;
    tick();
    sensor2 = 0;
    saw2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (switch2) saw2 = 1;
    end
    check("seq_drop", saw2, 1'b0);

    // Sequential with sensor2 held: served after route 1 and the gap.
    sensor1 = 1;
    tick();
    sensor1 = 0; sensor2 = 1;
    ticks(10);
    check("seq_held", switch2, 1'b1);
    sensor2 = 0;
    ticks(8);

    // Simultaneous after reset: route 1 first, then route 2 when released.
    rest = 0;
    ticks(2);
    rest = 1;
    sensor1 = 1; sensor2 = 1;
    ticks(20);
    check("sim_r1", switch1, 1'b1);
    check("sim_r2", switch2, 1'b0);
    sensor1 = 0;
    ticks(10);
    check("sim_then2", switch2, 1'b1);
    sensor2 = 0;
    ticks(8);

    // Round-robin: two short simultaneous bursts after reset.
    rest = 0;
    tick();
    rest = 1;
    ticks(2);
    for (int b = 0; b < 2; b++) begin
      saw1 = 0; saw2 = 0;
      sensor1 = 1; sensor2 = 1;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (switch1) saw1 = 1;
        if (switch2) saw2 = 1;
      end
      sensor1 = 0; sensor2 = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (switch1) saw1 = 1;
        if (switch2) saw2 = 1;
      end
      check($sformatf("rr%0d_sw1", b), saw1, (b == 0) ? 1'b1 : 1'b0);
      check($sformatf("rr%0d_sw2", b), saw2, (b == 0) ? 1'b0 : 1'b1);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 5) == 0) sensor1 = ~sensor1;
      if ($urandom_range(0, 5) == 0) sensor2 = ~sensor2;
      rest = ($urandom_range(0, 99) != 0);
      tick();
    end
    rest = 1; sensor1 = 0; sensor2 = 0;
    ticks(12);

    // Mid-route reset drops switch1 at that edge, then normal decoding.
    sensor1 = 1;
    ticks(5);
    check("mid_on", switch1, 1'b1);
    rest = 0;
    tick();
    check("mid_rst1", switch1, 1'b0);
    check("mid_rst2", switch2, 1'b0);
    rest = 1;
    ticks(6);
    check("mid_back", switch1, 1'b1);
    sensor1 = 0;
    ticks(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nd
`default_nettype wire

// File: doc/nd.md
ND -- requirements
Module: nd

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, cycles a route stays set after its synchronized sensor drops (range 1..255).
REQ-002 Parameter GAP_CYCLES, default 1, cycles both switches are forced off between routes (range 1..255).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rest  input  1  reset, synchronous, active-low.
REQ-005 sensor1  input  1  train-present detector, approach 1, asynchronous level, active-high.
REQ-006 sensor2  input  1  train-present detector, approach 2, asynchronous level, active-high.
REQ-007 switch1  output  1  registered; 1 = track set for route 1.
REQ-008 switch2  output  1  registered; 1 = track set for route 2.

Function
REQ-009 Each sensor SHALL pass through a 2-flop synchronizer; FSM uses only synchronized levels s1, s2.
REQ-010 FSM states SHALL be IDLE, ROUTE1, ROUTE2, HOLD1, HOLD2, GAP; outputs are Moore-decoded and registered: switch1=1 only in ROUTE1/HOLD1, switch2=1 only in ROUTE2/HOLD2.
REQ-011 switch1 and switch2 SHALL never be 1 in the same cycle.
REQ-012 IDLE: s1 only -> ROUTE1; s2 only -> ROUTE2; neither -> IDLE.
REQ-013 IDLE with s1 and s2 both 1: grant the route not granted last (round-robin via last_grant flag); after reset last_grant=2, so route 1 wins first.
REQ-014 ROUTEn: stay while sn=1; on sn=0 -> HOLDn with hold counter loaded to HOLD_CYCLES-1.
REQ-015 HOLDn: sn=1 -> back to ROUTEn (hold restarts); counter=0 -> GAP with gap counter loaded to GAP_CYCLES-1; else decrement.
REQ-016 GAP: both outputs 0; counter=0 -> IDLE; else decrement; sensors ignored (requests stay pending by level).
REQ-017 A request from the other sensor during ROUTEn/HOLDn SHALL NOT preempt; it is served from IDLE after GAP if still asserted.
REQ-018 Latency: sensorN rising sampled at edge k -> switchN=1 after edge k+3 (2 sync + 1 FSM/output register), from IDLE.
REQ-019 Release: s_n falls -> switchN stays 1 for HOLD_CYCLES further cycles, then 0 for at least GAP_CYCLES cycles before any switch rises.
REQ-020 last_grant SHALL update on every IDLE->ROUTEn transition.
REQ-021 Counters SHALL be 8 bits, never wrap below 0.

Reset
REQ-022 rest=0 at a rising edge SHALL force state IDLE, switch1=0, switch2=0, synchronizer flops 0, counters 0, last_grant=2.
REQ-023 Reset asserted mid-route SHALL drop both switches at that edge with no GAP; after release, normal IDLE decoding resumes.
REQ-024 Reset SHALL dominate all other inputs.

Structure
REQ-025 Package nd_pkg SHALL hold the state enum, counter width constant (8), and default HOLD/GAP values.
REQ-026 One sub-module nd_sync (2-flop synchronizer, reset to 0) SHALL be instantiated once per sensor.

Verification
REQ-027 Reset: rest=0 two cycles, sensors toggling -> switch1=0, switch2=0 throughout.
REQ-028 Single request: sensor1=1 for 1 cycle after reset -> switch1=1 from edge k+3 for 1+2 cycles, then 0; switch2 stays 0.
REQ-029 Sequential: sensor1 pulse, then sensor2 pulse next cycle -> switch1 route, 1-cycle gap with both 0 only if sensor2 still high at IDLE; otherwise sensor2 pulse dropped (level semantics), switch2=0.
REQ-030 Simultaneous: sensor1=sensor2=1 held 20 cycles from IDLE after reset -> switch1 granted; drop sensor1 -> after HOLD+GAP switch2=1.
REQ-031 Round-robin: two simultaneous request bursts -> first burst grants route 1, second grants route 2.
REQ-032 Mutual exclusion and mid-route reset: random sensor stimulus 1000 cycles with asserted check switch1&switch2==0; rest=0 during ROUTE1 -> switch1=0 next edge.
